audio_clk_gen: RTL and testbench
================================

// Module: audio_clk_gen
// PURPOSE
//  Downstream consumer of the audio PLL outputs. Runs on one PLL output clock and gates startup on the PLL lock flag.
//  After lock has been stable for a hold-off period, it generates the codec serial clocks (BCLK, LRCK).
//  It also produces clk-domain strobes for the I2S serializer/deserializer stage.
//  Loss of lock stops the clocks immediately and sets a sticky flag.
// PARAMETERS
//  BCLK_DIV     2     BCLK half-period in clk cycles (>=1); BCLK period = 2*BCLK_DIV clk
//  BITS_PER_CH  32    BCLK periods per LRCK half (channel slot), >=2
//  LOCK_HOLD    1024  clk cycles locked must stay high before clocks start (>=1)
// PORTS
//  clk          in   1  PLL output clock (10 MHz outclk_2 in the audio system)
//  rst          in   1  asynchronous, active-high reset
//  locked       in   1  PLL lock flag, asynchronous to clk
//  lock_clr     in   1  synchronous pulse; clears lock_lost
//  bclk         out  1  codec bit clock (registered)
//  lrck         out  1  codec word clock, 0 = left, 1 = right (registered)
//  bclk_fall    out  1  1-clk strobe, high in the cycle bclk first reads 0 after 1
//  frame_start  out  1  1-clk strobe, high in the cycle lrck first reads 0 (new L/R frame)
//  ready        out  1  high while state == RUN
//  lock_lost    out  1  sticky: lock dropped while in HOLD or RUN
// BEHAVIOUR
//  Reset: all outputs 0; state WAIT_LOCK; all counters 0; sync flops 0.
//  Lock sync: locked passes through 2 flops -> locked_s. No other logic reads raw locked.
//  States:
//   WAIT_LOCK: bclk=lrck=0, counters held at 0. On locked_s=1 -> HOLD, hold_cnt<=0.
//   HOLD: hold_cnt++ each cycle.
//    - locked_s=0 -> WAIT_LOCK, set lock_lost.
//    - hold_cnt==LOCK_HOLD-1 -> RUN.
//    - HOLD lasts exactly LOCK_HOLD cycles.
//   RUN: ready=1. locked_s=0 -> WAIT_LOCK the next edge.
//    - bclk, lrck, counters and strobes forced to 0 on that same edge; set lock_lost.
//  Latency: edge 1 is the first edge sampling locked=1. ready rises at edge LOCK_HOLD+3, provided locked stays high.
//  First RUN cycle: bclk=0, lrck=0, div_cnt=0, bit_cnt=0, frame_start=1.
//  Divider (RUN only):
//   - div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1, bclk toggles and div_cnt<=0.
//  Bit count on each bclk 1->0 toggle:
//   - bit_cnt wraps BITS_PER_CH-1 -> 0 and toggles lrck on the same edge, so lrck changes only with bclk falling.
//   - Otherwise bit_cnt++.
//  Strobes are registered alongside bclk/lrck:
//   - bclk_fall=1 in the same cycle bclk reads the new 0.
//   - frame_start=1 in the same cycle lrck reads the new 0.
//   - Both are 0 in all other cycles and in non-RUN states.
//  Periods: LRCK = 2*BITS_PER_CH*2*BCLK_DIV clk (defaults: 256 clk, 39.0625 kHz at 10 MHz).
//  lock_lost:
//   - Set has priority over lock_clr in the same cycle.
//   - Cleared only by lock_clr or rst.
//   - Its value does not block restart; the FSM re-arms from WAIT_LOCK.
//  Reset mid-RUN: asynchronous, all outputs 0 immediately. Restart requires a full LOCK_HOLD again.
//  Counter widths: $clog2 of the max count, min 1 bit; counters never exceed terminal value.
// TESTING
//  1. rst, then locked=1 at edge 1, LOCK_HOLD=8 -> ready=0 through edge 10; ready=1 and frame_start=1 at edge 11.
//  2. Defaults, run 1024 clk -> bclk period 4 clk 50% duty.
//     - lrck period 256 clk.
//     - frame_start every 256 clk.
//     - bclk_fall count = 256.
//     - lrck edges coincide with bclk_fall.
//  3. Drop locked for 1 clk midway through HOLD -> back to WAIT_LOCK, lock_lost=1, ready never asserts.
//     - Re-raise locked -> full LOCK_HOLD is counted again.
//  4. Drop locked in RUN -> 3 edges later (2 sync + 1): bclk=lrck=ready=0, lock_lost=1.
//     - lock_clr pulse then clears lock_lost to 0.
//  5. Assert rst asynchronously mid-RUN while bclk=1 -> all outputs 0 before the next clk edge; lock_lost=0.
//  6. BCLK_DIV=1, BITS_PER_CH=2 -> bclk toggles every clk, lrck period 8 clk.
//     - bit_cnt wrap and lrck toggle land on the same edge.
//     - lock_clr coincident with lock loss leaves lock_lost=1.

Source files
------------

// File: rtl/audio_clk_gen.sv
`timescale 1ns/1ps
// audio_clk_gen
//   Codec serial clock generator fed from an audio PLL output clock. Waits
//   for the PLL lock flag to be stable for LOCK_HOLD cycles, then produces
//   BCLK/LRCK plus clk-domain strobes for the I2S serializer. Losing lock
//   stops the clocks at once and raises a sticky lock_lost flag.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_LOCK | clocks parked low, waiting for synchronized lock
//   HOLD      | lock seen, counting LOCK_HOLD stable cycles
//   RUN       | BCLK/LRCK running, ready high
//
// Ports
//   clk          PLL output clock
//   rst          asynchronous active-high reset
//   locked       PLL lock flag (asynchronous, synchronized internally)
//   lock_clr     synchronous pulse clearing lock_lost
//   bclk         codec bit clock (registered)
//   lrck         codec word clock, 0 = left, 1 = right (registered)
//   bclk_fall    1-clk strobe in the first cycle bclk reads 0 after 1
//   frame_start  1-clk strobe in the first cycle lrck reads 0
//   ready        high while in RUN
//   lock_lost    sticky, set when lock drops during HOLD or RUN
module audio_clk_gen #(
    parameter int BCLK_DIV    = 2,
    parameter int BITS_PER_CH = 32,
    parameter int LOCK_HOLD   = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic lock_clr,
    output logic bclk,
    output logic lrck,
    output logic bclk_fall,
    output logic frame_start,
    output logic ready,
    output logic lock_lost
);

    localparam int DIV_W  = (BCLK_DIV > 1)    ? $clog2(BCLK_DIV)    : 1;
    localparam int BIT_W  = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;
    localparam int HOLD_W = (LOCK_HOLD > 1)   ? $clog2(LOCK_HOLD)   : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_CH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t state, state_nx;

    logic locked_m, locked_s;

    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [DIV_W-1:0]  div_cnt, div_nx;
    logic [BIT_W-1:0]  bit_cnt, bit_nx;
    logic bclk_nx, lrck_nx, fall_nx, frame_nx, lost_nx, lost_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_nx;
            div_cnt     <= div_nx;
            bit_cnt     <= bit_nx;
            bclk        <= bclk_nx;
            lrck        <= lrck_nx;
            bclk_fall   <= fall_nx;
            frame_start <= frame_nx;
            lock_lost   <= lost_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        bclk_nx  = bclk;
        lrck_nx  = lrck;
        fall_nx  = 1'b0;
        frame_nx = 1'b0;
        lost_set = 1'b0;

        case (state)
            WAIT_LOCK: begin
                hold_nx = '0;
                div_nx  = '0;
                bit_nx  = '0;
                bclk_nx = 1'b0;
                lrck_nx = 1'b0;
                if (locked_s) state_nx = HOLD;
            end
            HOLD: begin
                div_nx  = '0;
                bit_nx  = '0;
                bclk_nx = 1'b0;
                lrck_nx = 1'b0;
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    hold_nx  = '0;
                    lost_set = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    // Entering RUN with lrck=0 counts as the first frame.
                    state_nx = RUN;
                    hold_nx  = '0;
                    frame_nx = 1'b1;
                end else begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    div_nx   = '0;
                    bit_nx   = '0;
                    bclk_nx  = 1'b0;
                    lrck_nx  = 1'b0;
                    lost_set = 1'b1;
                end else if (div_cnt == DIV_LAST) begin
                    div_nx  = '0;
                    bclk_nx = ~bclk;
                    // Bit/word bookkeeping happens only on the falling toggle,
                    // so lrck always changes together with bclk going low.
                    if (bclk) begin
                        fall_nx = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_nx   = '0;
                            lrck_nx  = ~lrck;
                            frame_nx = lrck;
                        end else begin
                            bit_nx = bit_cnt + BIT_W'(1);
                        end
                    end
                end else begin
                    div_nx = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
            end
        endcase

        // Setting wins over a coincident clear.
        if (lost_set)      lost_nx = 1'b1;
        else if (lock_clr) lost_nx = 1'b0;
        else               lost_nx = lock_lost;
    end

    assign ready = (state == RUN);

endmodule

// File: tb/tb_audio_clk_gen.sv
`timescale 1ns/1ps
module tb_audio_clk_gen;

    localparam int D_A = 2, B_A = 32, H_A = 8;
    localparam int D_B = 1, B_B = 2,  H_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, locked_a, clr_a;
    logic bclk_a, lrck_a, fall_a, frame_a, ready_a, lost_a;
    logic rst_b, locked_b, clr_b;
    logic bclk_b, lrck_b, fall_b, frame_b, ready_b, lost_b;

    audio_clk_gen #(.BCLK_DIV(D_A), .BITS_PER_CH(B_A), .LOCK_HOLD(H_A)) dut_a (
        .clk(clk), .rst(rst_a), .locked(locked_a), .lock_clr(clr_a),
        .bclk(bclk_a), .lrck(lrck_a), .bclk_fall(fall_a),
        .frame_start(frame_a), .ready(ready_a), .lock_lost(lost_a)
    );

    audio_clk_gen #(.BCLK_DIV(D_B), .BITS_PER_CH(B_B), .LOCK_HOLD(H_B)) dut_b (
        .clk(clk), .rst(rst_b), .locked(locked_b), .lock_clr(clr_b),
        .bclk(bclk_b), .lrck(lrck_b), .bclk_fall(fall_b),
        .frame_start(frame_b), .ready(ready_b), .lock_lost(lost_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outputs follow from how many consecutive edges the
    // synchronized lock has been seen high (streak). RUN time t starts at
    // streak = LOCK_HOLD+1; clocks are plain divisions of t.
    typedef struct {
        bit s1;
        bit s2;
        int streak;
        bit lost;
    } mdl_t;

    typedef struct packed {
        logic ready;
        logic bclk;
        logic lrck;
        logic fall;
        logic frame;
        logic lost;
    } obs_t;

    function automatic mdl_t mdl_step(mdl_t m, logic lk, logic clr);
        mdl_t n;
        n = m;
        n.s2 = m.s1;
        n.s1 = lk;
        n.streak = m.s2 ? m.streak + 1 : 0;
        if (!m.s2 && m.streak > 0) n.lost = 1'b1;
        else if (clr)              n.lost = 1'b0;
        return n;
    endfunction

    function automatic obs_t mdl_out(mdl_t m, int d, int b, int h);
        obs_t o;
        bit run;
        int t;
        run = (m.streak >= h + 1);
        t = run ? m.streak - h - 1 : 0;
        o.ready = run;
        o.bclk  = run && ((t / d) % 2 == 1);
        o.lrck  = run && ((t / (2 * d * b)) % 2 == 1);
        o.fall  = run && (t > 0) && (t % (2 * d) == 0);
        o.frame = run && (t % (4 * d * b) == 0);
        o.lost  = m.lost;
        return o;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.s1 = 1'b0; m.s2 = 1'b0; m.streak = 0; m.lost = 1'b0;
        return m;
    endfunction

    mdl_t m_a, m_b;
    obs_t q_a[$];
    obs_t q_b[$];

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            m_a <= mdl_reset();
            q_a.delete();
            q_a.push_back(mdl_out(mdl_reset(), D_A, B_A, H_A));
        end else begin
            m_a <= mdl_step(m_a, locked_a, clr_a);
            q_a.push_back(mdl_out(mdl_step(m_a, locked_a, clr_a), D_A, B_A, H_A));
        end
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            m_b <= mdl_reset();
            q_b.delete();
            q_b.push_back(mdl_out(mdl_reset(), D_B, B_B, H_B));
        end else begin
            m_b <= mdl_step(m_b, locked_b, clr_b);
            q_b.push_back(mdl_out(mdl_step(m_b, locked_b, clr_b), D_B, B_B, H_B));
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string who, input obs_t e, input obs_t a,
                           input logic prev_lrck, input logic prev_ready);
        chk({who, ".ready"},       a.ready, e.ready);
        chk({who, ".bclk"},        a.bclk,  e.bclk);
        chk({who, ".lrck"},        a.lrck,  e.lrck);
        chk({who, ".bclk_fall"},   a.fall,  e.fall);
        chk({who, ".frame_start"}, a.frame, e.frame);
        chk({who, ".lock_lost"},   a.lost,  e.lost);
        if (a.ready && prev_ready && (a.lrck != prev_lrck))
            chk({who, ".lrck_edge_on_fall"}, a.fall, 1'b1);
    endtask

    logic pl_a = 1'b0, pr_a = 1'b0, pl_b = 1'b0, pr_b = 1'b0;

    always @(negedge clk) begin
        if (q_a.size() > 0)
            cmp_obs("a", q_a.pop_front(),
                    obs_t'{ready_a, bclk_a, lrck_a, fall_a, frame_a, lost_a}, pl_a, pr_a);
        if (q_b.size() > 0)
            cmp_obs("b", q_b.pop_front(),
                    obs_t'{ready_b, bclk_b, lrck_b, fall_b, frame_b, lost_b}, pl_b, pr_b);
        pl_a <= lrck_a;
        pr_a <= ready_a;
        pl_b <= lrck_b;
        pr_b <= ready_b;
    end

    task automatic edges_to_ready_a(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready_a && n < limit);
    endtask

    initial begin
        int n, n_fall, n_frame, n_high, t0, left_a, left_b;
        logic pb;

        rst_a = 1'b1; rst_b = 1'b1;
        locked_a = 1'b0; locked_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready_a, 1'b0);
        chk("reset_bclk", bclk_a, 1'b0);
        chk("reset_lost", lost_a, 1'b0);

        // Startup latency: edge 1 is the first edge sampling locked=1.
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        locked_a = 1'b1; locked_b = 1'b1;
        for (int e = 1; e <= H_A + 3; e++) begin
            @(posedge clk); #1;
            chk("t1_ready", ready_a, (e >= H_A + 3));
        end
        chk("t1_frame", frame_a, 1'b1);

        // 1024 RUN cycles at default divider settings.
        n_fall = 0; n_frame = 0; n_high = 0;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk); #1;
            n_fall  += int'(fall_a);
            n_frame += int'(frame_a);
            n_high  += int'(bclk_a);
        end
        chk_int("t2_bclk_fall_count", n_fall, 256);
        chk_int("t2_frame_count", n_frame, 4);
        chk_int("t2_bclk_high_cycles", n_high, 512);

        // Lock glitch during HOLD.
        locked_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_wait_lost", lost_a, 1'b1);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        locked_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        locked_a = 1'b0;
        @(posedge clk); #1;
        locked_a = 1'b1;
        edges_to_ready_a(40, n);
        chk_int("t3_full_hold_again", n, H_A + 3);
        chk("t3_lost", lost_a, 1'b1);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("t3_clr", lost_a, 1'b0);

        // Lock loss in RUN: three edges to stop.
        locked_a = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            chk("t4_ready", ready_a, (e < 3));
        end
        chk("t4_bclk", bclk_a, 1'b0);
        chk("t4_lrck", lrck_a, 1'b0);
        chk("t4_lost", lost_a, 1'b1);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("t4_clr", lost_a, 1'b0);

        // Async reset mid-RUN while bclk is high.
        locked_a = 1'b1;
        edges_to_ready_a(40, n);
        chk_int("t5_relock", n, H_A + 3);
        n = 0;
        while (!bclk_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_bclk_high", bclk_a, 1'b1);
        #2 rst_a = 1'b1;
        #1;
        chk("t5_rst_bclk", bclk_a, 1'b0);
        chk("t5_rst_lrck", lrck_a, 1'b0);
        chk("t5_rst_ready", ready_a, 1'b0);
        chk("t5_rst_fall", fall_a, 1'b0);
        chk("t5_rst_frame", frame_a, 1'b0);
        chk("t5_rst_lost", lost_a, 1'b0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        edges_to_ready_a(40, n);
        chk_int("t5_restart", n, H_A + 3);

        // Fast configuration on dut_b, running since startup.
        pb = bclk_b;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("t6_bclk_toggle", bclk_b, ~pb);
            pb = bclk_b;
        end
        n = 0;
        while (!frame_b && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        t0 = n;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!frame_b && n < 40);
        chk_int("t6_lrck_period", n - t0, 4 * D_B * B_B);

        locked_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr_b = 1'b1;
        @(posedge clk); #1;
        clr_b = 1'b0;
        chk("t6_set_beats_clr", lost_b, 1'b1);
        chk("t6_stopped", ready_b, 1'b0);

        // Randomized lock activity on both instances.
        left_a = 0; left_b = 0;
        for (int k = 0; k < 15000; k++) begin
            @(posedge clk); #1;
            if (left_a == 0) begin
                locked_a = ~locked_a;
                left_a = locked_a ? int'($urandom_range(1, 1400)) : int'($urandom_range(1, 12));
            end else begin
                left_a--;
            end
            if (left_b == 0) begin
                locked_b = ~locked_b;
                left_b = locked_b ? int'($urandom_range(1, 120)) : int'($urandom_range(1, 8));
            end else begin
                left_b--;
            end
            clr_a = ($urandom_range(0, 39) == 0);
            clr_b = ($urandom_range(0, 39) == 0);
        end
        clr_a = 1'b0; clr_b = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
